mmio_port_bank: RTL and testbench



---
 rtl/mmio_port_bank.sv | 129 ++++++++++++
 tb/tb_mmio_port_bank.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mmio_port_bank.sv
// mmio_port_bank: memory-mapped I/O bank for the MEM stage.
// N_IN debounced input ports are readable and N_OUT output registers are
// writable inside a 128-byte window at BASE_ADDR; port k sits at BASE + 4*k.
// Optional build macro MMIO_EDGE_CAPTURE_EN adds a write-1-to-clear event
// status register at index 16 (BASE + 0x40).
//
// Bus semantics: there is no handshake. addr is decoded every cycle, rdata and
// io_hit are combinational from addr, and a store (we=1) inside the window
// commits on the rising edge of clock. Reads never have side effects.
module mmio_port_bank #(
  parameter int                DATA_W          = 32,
  parameter int                N_IN            = 2,
  parameter int                IN_W            = 5,
  parameter int                N_OUT           = 3,
  parameter logic [DATA_W-1:0] BASE_ADDR       = 'h80,
  parameter int                DEBOUNCE_CYCLES = 16
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [DATA_W-1:0]       addr,
  input  logic                    we,
  input  logic [DATA_W-1:0]       wdata,
  output logic [DATA_W-1:0]       rdata,
  output logic                    io_hit,
  input  logic [N_IN*IN_W-1:0]    sw_in,
  output logic [N_OUT*DATA_W-1:0] out_port
);

  localparam int             CNT_W      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [4:0]     STATUS_IDX = 5'd16;

  logic [4:0]       idx;
  logic [1:0]       unused_addr;
  logic [IN_W-1:0]  sync1  [N_IN];
  logic [IN_W-1:0]  sync2  [N_IN];
  logic [IN_W-1:0]  stable [N_IN];
  logic [CNT_W-1:0] cnt    [N_IN];
  logic [N_IN-1:0]  accept;

  assign idx         = addr[6:2];
  assign unused_addr = addr[1:0];
  assign io_hit      = (addr[DATA_W-1:7] == BASE_ADDR[DATA_W-1:7]);

  // A port accepts its synchronised value once it has differed from the
  // stable value for DEBOUNCE_CYCLES consecutive edges.
  always_comb begin
    accept = '0;
    for (int i = 0; i < N_IN; i++) begin
      accept[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_MAX);
    end
  end

  // Per-port two-flop synchroniser and whole-vector debounce counter.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < N_IN; i++) begin
        sync1[i]  <= '0;
        sync2[i]  <= '0;
        stable[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        sync1[i] <= sw_in[i*IN_W +: IN_W];
        sync2[i] <= sync1[i];
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Output registers: a store inside the window updates the addressed port.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_port <= '0;
    end else begin
      for (int j = 0; j < N_OUT; j++) begin
        if (we && io_hit && (idx == 5'(j))) begin
          out_port[j*DATA_W +: DATA_W] <= wdata;
        end
      end
    end
  end

`ifdef MMIO_EDGE_CAPTURE_EN
  logic [N_IN-1:0] evt;
  logic [N_IN-1:0] evt_clr;

  assign evt_clr = (we && io_hit && (idx == STATUS_IDX)) ? wdata[N_IN-1:0] : '0;

  // Event status: set when a port's stable value changes, W1C; set beats clear.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      evt <= '0;
    end else begin
      evt <= (evt & ~evt_clr) | accept;
    end
  end
`endif

  // Read mux: debounced inputs first, then the optional status register.
  always_comb begin
    rdata = '0;
    if (io_hit) begin
      for (int i = 0; i < N_IN; i++) begin
        if (idx == 5'(i)) begin
          rdata = DATA_W'(stable[i]);
        end
      end
`ifdef MMIO_EDGE_CAPTURE_EN
      if (idx == STATUS_IDX) begin
        rdata = DATA_W'(evt);
      end
`else
      if (idx == STATUS_IDX) begin
        rdata = '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mmio_port_bank.sv
// Directed bench for mmio_port_bank (default parameters). Inputs are driven
// and outputs sampled 1 time unit after the rising edge.
module tb_mmio_port_bank;

  localparam int DB = 16;

  logic        clock = 1'b0;
  logic        resetn;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        io_hit;
  logic [9:0]  sw_in;
  logic [95:0] out_port;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  mmio_port_bank dut (
    .clock    (clock),
    .resetn   (resetn),
    .addr     (addr),
    .we       (we),
    .wdata    (wdata),
    .rdata    (rdata),
    .io_hit   (io_hit),
    .sw_in    (sw_in),
    .out_port (out_port)
  );

  // clock
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] e);
    addr = a;
    we   = 1'b0;
    #1;
    check(tag, rdata, e);
  endtask

  task automatic hit_chk(input string tag, input logic [31:0] a, input logic e);
    addr = a;
    #1;
    check(tag, {31'b0, io_hit}, {31'b0, e});
  endtask

  task automatic write(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    edges(1);
    we    = 1'b0;
  endtask

  task automatic out_chk(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                         input logic [31:0] e2);
    check({tag, "_o0"}, out_port[31:0],  e0);
    check({tag, "_o1"}, out_port[63:32], e1);
    check({tag, "_o2"}, out_port[95:64], e2);
  endtask

  // Input was changed just after edge 0: reads stay at old until edge DB+1,
  // the new value appears from edge DB+2.
  task automatic expect_accept(input string tag, input logic [31:0] a,
                               input logic [31:0] old_v, input logic [31:0] new_v);
    for (int e = 1; e <= DB + 2; e++) exp_q.push_back((e < DB + 2) ? old_v : new_v);
    for (int e = 1; e <= DB + 2; e++) begin
      edges(1);
      read_chk($sformatf("%s_e%0d", tag, e), a, exp_q.pop_front());
    end
  endtask

  initial begin
    resetn = 1'b0;
    addr   = 32'h80;
    we     = 1'b0;
    wdata  = '0;
    sw_in  = '0;
    edges(3);
    resetn = 1'b1;
    edges(1);

    // reset state and decode
    read_chk("rst_rd80", 32'h80, 32'h0);
    read_chk("rst_rd84", 32'h84, 32'h0);
    read_chk("rst_rd88", 32'h88, 32'h0);
    out_chk("rst", 32'h0, 32'h0, 32'h0);
    hit_chk("hit80", 32'h80, 1'b1);
    hit_chk("hit84", 32'h84, 1'b1);
    hit_chk("hit88", 32'h88, 1'b1);
    hit_chk("hit7c", 32'h7C, 1'b0);
    hit_chk("hitfc", 32'hFC, 1'b1);
    hit_chk("hit100", 32'h100, 1'b0);

    // stores
    write(32'h84, 32'h0000002A);
    out_chk("wr84", 32'h0, 32'h2A, 32'h0);
    write(32'h8C, 32'hFFFF_FFFF);
    out_chk("wr8c", 32'h0, 32'h2A, 32'h0);
    write(32'h89, 32'h0000_0055);
    out_chk("wr89", 32'h0, 32'h2A, 32'h55);
    write(32'h180, 32'h1234_5678);
    out_chk("wr_miss", 32'h0, 32'h2A, 32'h55);
    read_chk("rd88_out", 32'h88, 32'h0);
    read_chk("rd_miss", 32'h100, 32'h0);
`ifndef MMIO_EDGE_CAPTURE_EN
    write(32'hC0, 32'hFFFF_FFFF);
    read_chk("rdc0_off", 32'hC0, 32'h0);
    out_chk("wrc0_off", 32'h0, 32'h2A, 32'h55);
`endif

    // debounce acceptance latency on port 0
    addr = 32'h80;
    sw_in[4:0] = 5'b10110;
    expect_accept("db0", 32'h80, 32'h0, 32'h16);

    // glitch on port 1 is rejected and leaves the count cleared
    sw_in[9:5] = 5'b00001;
    for (int e = 0; e < 10; e++) begin
      edges(1);
      read_chk($sformatf("gl_hi%0d", e), 32'h84, 32'h0);
    end
    sw_in[9:5] = 5'b00000;
    for (int e = 0; e < 6; e++) begin
      edges(1);
      read_chk($sformatf("gl_lo%0d", e), 32'h84, 32'h0);
    end
    sw_in[9:5] = 5'b00001;
    expect_accept("db1", 32'h84, 32'h0, 32'h1);
    read_chk("db1_p0", 32'h80, 32'h16);

    // reset in the middle of a debounce
    sw_in[4:0] = 5'b01001;
    edges(8);
    resetn = 1'b0;
    read_chk("mid_rd80", 32'h80, 32'h0);
    read_chk("mid_rd84", 32'h84, 32'h0);
    out_chk("mid", 32'h0, 32'h0, 32'h0);
    edges(2);
    resetn = 1'b1;
    expect_accept("rel", 32'h80, 32'h0, 32'h09);

`ifdef MMIO_EDGE_CAPTURE_EN
    write(32'hC0, 32'hFFFF_FFFF);
    read_chk("evt_clr_all", 32'hC0, 32'h0);
    sw_in[4:0] = 5'b00011;
    expect_accept("ev_db", 32'h80, 32'h09, 32'h3);
    read_chk("evt_set", 32'hC0, 32'h1);
    write(32'hC0, 32'h1);
    read_chk("evt_w1c", 32'hC0, 32'h0);
    sw_in[4:0] = 5'b00000;
    edges(DB + 1);
    read_chk("evt_pre", 32'h80, 32'h3);
    write(32'hC0, 32'h1);
    read_chk("evt_setwins", 32'hC0, 32'h1);
    read_chk("evt_p0", 32'h80, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
